// File: rtl/stage4_scoreboard_hazard_unit.sv
// Per-register in-flight write scoreboard: stalls issue on RAW against any outstanding write and on
// WAW when a register already holds MAX_INFLIGHT pending writes. Optional SCOREBOARD_BYPASS_EN.
module stage4_scoreboard_hazard_unit #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned NSRC         = 2,
  parameter int unsigned NWB          = 2,
  parameter int unsigned MAX_INFLIGHT = 3,
  localparam int unsigned RW = $clog2(NREGS),
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1),
  localparam int unsigned PW = $clog2(NREGS * MAX_INFLIGHT + 1),
  localparam int unsigned HW = $clog2(NWB + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                issue_valid,
  input  logic                issue_wen,
  input  logic [RW-1:0]       issue_rd,
  input  logic [NSRC-1:0]     src_used,
  input  logic [NSRC*RW-1:0]  src_rs,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*RW-1:0]   wb_rd,
  input  logic                flush_all,
  output logic                stall,
  output logic                pending_any,
  output logic [PW-1:0]       pending_total,
  output logic                sb_error
);

  logic [CW-1:0] cnt_q   [NREGS];
  logic [CW-1:0] cnt_d   [NREGS];
  logic [HW-1:0] wb_hits [NREGS];
  logic          sb_error_q;
  logic          sb_error_d;
  logic          underflow;
  logic          raw_hit;
  logic          waw_hit;
  logic          accept;

  // Writebacks per register this cycle; several ports may retire the same register.
  always_comb begin : wb_decode
    for (int r = 0; r < NREGS; r++) begin
      wb_hits[r] = '0;
      for (int j = 0; j < NWB; j++) begin
        if (r != 0 && wb_valid[j] && wb_rd[j*RW +: RW] == RW'(r)) begin
          wb_hits[r] = wb_hits[r] + HW'(1);
        end
      end
    end
  end

  always_comb begin : hazard
    logic [RW-1:0] rs;
    rs      = '0;
    raw_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      rs = src_rs[i*RW +: RW];
`ifdef SCOREBOARD_BYPASS_EN
      // Writes completing this cycle are forwarded by the datapath.
      if (src_used[i] && rs != '0 && int'(cnt_q[rs]) > int'(wb_hits[rs])) begin
        raw_hit = 1'b1;
      end
`else
      if (src_used[i] && rs != '0 && cnt_q[rs] != '0) begin
        raw_hit = 1'b1;
      end
`endif
    end
    // Same-cycle writebacks deliberately do not relieve the WAW limit.
    waw_hit = issue_wen && issue_rd != '0 && cnt_q[issue_rd] == CW'(MAX_INFLIGHT);
    stall   = issue_valid && (raw_hit || waw_hit);
    accept  = issue_valid && !stall;
  end

  always_comb begin : next_state
    int net;
    net       = 0;
    underflow = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = '0;
      if (r != 0) begin
        net = int'(cnt_q[r]) - int'(wb_hits[r]);
        if (accept && issue_wen && issue_rd == RW'(r)) begin
          net = net + 1;
        end
        if (net < 0) begin
          underflow = 1'b1;
          net       = 0;
        end
        cnt_d[r] = CW'(net);
      end
    end
    sb_error_d = sb_error_q | underflow;
    if (flush_all) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_d[r] = '0;
      end
      sb_error_d = sb_error_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      sb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      sb_error_q <= sb_error_d;
    end
  end

  always_comb begin : totals
    pending_total = '0;
    for (int r = 1; r < NREGS; r++) begin
      pending_total = pending_total + PW'(cnt_q[r]);
    end
    pending_any = pending_total != '0;
  end

  assign sb_error = sb_error_q;

endmodule

// File: tb/tb_stage4_scoreboard_hazard_unit.sv
// Directed bench for stage4_scoreboard_hazard_unit (default parameters); follows SCOREBOARD_BYPASS_EN.
module tb_stage4_scoreboard_hazard_unit;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       issue_valid;
  logic       issue_wen;
  logic [4:0] issue_rd;
  logic [1:0] src_used;
  logic [9:0] src_rs;
  logic [1:0] wb_valid;
  logic [9:0] wb_rd;
  logic       flush_all;
  logic       stall;
  logic       pending_any;
  logic [6:0] pending_total;
  logic       sb_error;

  int checks = 0;
  int errors = 0;

  stage4_scoreboard_hazard_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .issue_valid   (issue_valid),
    .issue_wen     (issue_wen),
    .issue_rd      (issue_rd),
    .src_used      (src_used),
    .src_rs        (src_rs),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush_all     (flush_all),
    .stall         (stall),
    .pending_any   (pending_any),
    .pending_total (pending_total),
    .sb_error      (sb_error)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_rd    = '0;
    src_used    = '0;
    src_rs      = '0;
    wb_valid    = '0;
    wb_rd       = '0;
    flush_all   = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = rd;
    tick();
    idle();
  endtask

  task automatic do_wb(input logic [4:0] rd0, input logic v1, input logic [4:0] rd1);
    idle();
    wb_valid = {v1, 1'b1};
    wb_rd    = {rd1, rd0};
    tick();
    idle();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle();
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", pending_any); end
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL reset_total got %0d want 0", pending_total); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", sb_error); end
    RST = 1'b0;
    do_issue(5'd5);
    do_issue(5'd5);
    checks++; if (pending_total !== 7'd2) begin errors++; $display("FAIL pre_rst_total got %0d want 2", pending_total); end
    #2 RST = 1'b1;
    #1;
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL async_rst_total got %0d want 0", pending_total); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL async_rst_any got %b want 0", pending_any); end
    tick();
    RST = 1'b0;
    do_wb(5'd5, 1'b0, 5'd0);
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL late_wb_err got %b want 1", sb_error); end
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL late_wb_total got %0d want 0", pending_total); end
    do_issue(5'd2);
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", sb_error); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", sb_error); end
  endtask

  task automatic test_raw();
    do_issue(5'd5);
    issue_valid = 1'b1;
    src_used    = 2'b01;
    src_rs      = {5'd0, 5'd5};
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_next got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_hold got %b want 1", stall); end
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd5};
    #1;
    checks++; if (stall !== !Byp) begin errors++; $display("FAIL raw_wb_cycle got %b want %b", stall, !Byp); end
    tick();
    wb_valid = '0;
    wb_rd    = '0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_after got %b want 0", stall); end
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL raw_total got %0d want 0", pending_total); end
    // Second source slot also checked.
    do_issue(5'd12);
    issue_valid = 1'b1;
    src_used    = 2'b10;
    src_rs      = {5'd12, 5'd0};
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_src1 got %b want 1", stall); end
    src_used = 2'b00;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_unused got %b want 0", stall); end
    idle();
    do_wb(5'd12, 1'b0, 5'd0);
  endtask

  task automatic test_waw();
    do_issue(5'd7);
    do_issue(5'd7);
    do_issue(5'd7);
    checks++; if (pending_total !== 7'd3) begin errors++; $display("FAIL waw_total3 got %0d want 3", pending_total); end
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = 5'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_limit got %b want 1", stall); end
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd7};
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_wb_same got %b want 1", stall); end
    tick();
    wb_valid = '0;
    wb_rd    = '0;
    #1;
    checks++; if (pending_total !== 7'd2) begin errors++; $display("FAIL waw_total2 got %0d want 2", pending_total); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_release got %b want 0", stall); end
    tick();
    idle();
    checks++; if (pending_total !== 7'd3) begin errors++; $display("FAIL waw_reissue got %0d want 3", pending_total); end
    do_wb(5'd7, 1'b1, 5'd7);
    do_wb(5'd7, 1'b0, 5'd0);
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL waw_drain got %0d want 0", pending_total); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL waw_err got %b want 0", sb_error); end
  endtask

  task automatic test_dual_wb();
    do_issue(5'd9);
    do_issue(5'd9);
    checks++; if (pending_total !== 7'd2) begin errors++; $display("FAIL dual_pre got %0d want 2", pending_total); end
    do_wb(5'd9, 1'b1, 5'd9);
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL dual_total got %0d want 0", pending_total); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL dual_any got %b want 0", pending_any); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL dual_err got %b want 0", sb_error); end
  endtask

  task automatic test_same_cycle();
    do_issue(5'd6);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = 5'd6;
    wb_valid    = 2'b01;
    wb_rd       = {5'd0, 5'd6};
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_stall got %b want 0", stall); end
    tick();
    idle();
    checks++; if (pending_total !== 7'd1) begin errors++; $display("FAIL same_total got %0d want 1", pending_total); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL same_err got %b want 0", sb_error); end
    do_wb(5'd6, 1'b0, 5'd0);
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL same_drain got %b want 0", pending_any); end
  endtask

  task automatic test_x0();
    for (int k = 0; k < 4; k++) begin
      idle();
      issue_valid = 1'b1;
      issue_wen   = 1'b1;
      issue_rd    = 5'd0;
      src_used    = 2'b11;
      src_rs      = '0;
      wb_valid    = 2'b01;
      wb_rd       = '0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall[%0d] got %b want 0", k, stall); end
      tick();
      checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL x0_total[%0d] got %0d want 0", k, pending_total); end
    end
    idle();
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL x0_err got %b want 0", sb_error); end
  endtask

  task automatic test_flush();
    do_issue(5'd4);
    checks++; if (pending_any !== 1'b1) begin errors++; $display("FAIL flush_pre got %b want 1", pending_any); end
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = 5'd3;
    wb_valid    = 2'b01;
    wb_rd       = {5'd0, 5'd4};
    flush_all   = 1'b1;
    tick();
    idle();
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL flush_total got %0d want 0", pending_total); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL flush_any got %b want 0", pending_any); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", sb_error); end
    issue_valid = 1'b1;
    src_used    = 2'b01;
    src_rs      = {5'd0, 5'd3};
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_src3 got %b want 0", stall); end
    idle();
  endtask

  task automatic test_underflow();
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = 5'd11;
    wb_valid    = 2'b11;
    wb_rd       = {5'd11, 5'd11};
    tick();
    idle();
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL uflow_err got %b want 1", sb_error); end
    checks++; if (pending_total !== 7'd0) begin errors++; $display("FAIL uflow_total got %0d want 0", pending_total); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_dual_wb();
    test_same_cycle();
    test_x0();
    test_flush();
    test_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
